// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx byte channel between N_SRC FWFT reply FIFOs.
// Two cycles from request to tx_valid, then one byte per two cycles; tx_valid/tx_data hold while tx_ready is low.
module uart_tx_arbiter #(
    parameter int N_SRC     = 2,
    parameter int STALL_MAX = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         src_empty,
    input  logic [8*N_SRC-1:0]       src_rd_data,
    input  logic [N_SRC-1:0]         src_last,
    output logic [N_SRC-1:0]         src_rd_en,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(N_SRC)-1:0] grant,
    output logic                     busy,
    output logic                     stall_abort
);
    localparam int GW = $clog2(N_SRC);
    localparam int CW = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

    state_t          r_state;
    logic            r_last;
    logic [CW-1:0]   r_stall;

    logic [GW-1:0]    w_next;
    logic             w_any;
    logic             w_head_vld;
    logic [7:0]       w_head_dat;
    logic             w_head_last;
    logic [N_SRC-1:0] w_sel;

    // Rotating search: the lowest requester above grant wins, else the lowest at or below it.
    always_comb begin
        w_next = grant;
        w_any  = 1'b0;
        for (int s = N_SRC - 1; s >= 0; s--) begin
            if (!src_empty[s] && s <= int'(grant)) begin
                w_next = GW'(s);
                w_any  = 1'b1;
            end
        end
        for (int s = N_SRC - 1; s >= 0; s--) begin
            if (!src_empty[s] && s > int'(grant)) begin
                w_next = GW'(s);
                w_any  = 1'b1;
            end
        end
    end

    always_comb begin
        w_head_vld  = 1'b0;
        w_head_dat  = 8'h00;
        w_head_last = 1'b0;
        w_sel       = '0;
        for (int s = 0; s < N_SRC; s++) begin
            if (GW'(s) == grant) begin
                w_head_vld  = !src_empty[s];
                w_head_dat  = src_rd_data[8*s +: 8];
                w_head_last = src_last[s];
                w_sel[s]    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b0;
            r_stall     <= '0;
            grant       <= GW'(N_SRC - 1);
            src_rd_en   <= '0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            stall_abort <= 1'b0;
        end else begin
            src_rd_en   <= '0;
            stall_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        grant   <= w_next;
                        r_stall <= '0;
                        r_state <= S_LOAD;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_head_vld) begin
                        tx_data   <= w_head_dat;
                        r_last    <= w_head_last;
                        src_rd_en <= w_sel;
                        tx_valid  <= 1'b1;
                        r_stall   <= '0;
                        r_state   <= S_SEND;
                    end else if (r_stall >= CW'(STALL_MAX - 1)) begin
                        // grant is kept so the next search starts past the stalled source
                        r_stall     <= CW'(STALL_MAX);
                        stall_abort <= 1'b1;
                        r_state     <= S_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        r_stall <= r_stall + CW'(1);
                    end
                end
                S_SEND: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        if (r_last) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-backed sources, a cycle reference model and a per-source byte-order scoreboard.
module tb_uart_tx_arbiter;
    localparam int N  = 2;
    localparam int SM = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     src_empty;
    logic [8*N-1:0]   src_rd_data;
    logic [N-1:0]     src_last;
    logic [N-1:0]     src_rd_en;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [0:0]       grant;
    logic             busy;
    logic             stall_abort;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_SRC(N), .STALL_MAX(SM)) dut (
        .clk(clk), .rst(rst), .src_empty(src_empty), .src_rd_data(src_rd_data),
        .src_last(src_last), .src_rd_en(src_rd_en), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .grant(grant), .busy(busy), .stall_abort(stall_abort)
    );

    logic [8:0] fq[N][$];
    logic [7:0] hist[N][$];
    logic [7:0] txlog[$];
    int  sent_idx[N];
    int  rd_pulses[N];
    bit  hold[N];
    int  hold_cnt[N];
    int  aborts;
    int  steps;
    int  n_chk = 0;
    int  n_pass = 0;

    // reference model: m_phase 0 = waiting for a requester, 1 = fetching a byte, 2 = presenting a byte
    int         m_phase, m_grant, m_wait;
    bit         m_last, m_valid, m_busy, m_abort;
    logic [7:0] m_data;
    logic [N-1:0] m_rd_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] logget(input int i);
        return (txlog.size() > i) ? {24'h0, txlog[i]} : 32'h1FF;
    endfunction

    function automatic bit src_has(input int c);
        return !hold[c] && fq[c].size() > 0;
    endfunction

    task automatic push(input int s, input logic [7:0] b, input bit last);
        fq[s].push_back({last, b});
        hist[s].push_back(b);
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < N; i++) begin
            src_empty[i] = !src_has(i);
            src_rd_data[8*i +: 8] = (fq[i].size() > 0) ? fq[i][0][7:0] : 8'($urandom);
            src_last[i] = (fq[i].size() > 0) ? fq[i][0][8] : 1'($urandom);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_grant = N - 1; m_wait = 0; m_last = 0;
        m_valid = 0; m_busy = 0; m_abort = 0; m_data = 8'h00; m_rd_en = '0;
    endtask

    task automatic step();
        int g, n_phase, n_grant, n_wait;
        bit n_last, n_valid, n_abort, found;
        logic [7:0] n_data;
        logic [N-1:0] n_rd_en, pop;
        drive_srcs();
        if (tx_valid && tx_ready) begin
            g = int'(grant);
            txlog.push_back(tx_data);
            if (sent_idx[g] < hist[g].size()) check("byte_order", tx_data, hist[g][sent_idx[g]]);
            else check("extra_byte", sent_idx[g], hist[g].size());
            sent_idx[g]++;
        end
        for (int i = 0; i < N; i++) if (src_rd_en[i]) rd_pulses[i]++;
        if (stall_abort) aborts++;
        n_phase = m_phase; n_grant = m_grant; n_wait = m_wait; n_last = m_last;
        n_valid = m_valid; n_data = m_data; n_abort = 0; n_rd_en = '0; found = 0;
        if (m_phase == 0) begin
            for (int k = 1; k <= N; k++)
                if (!found && src_has((m_grant + k) % N)) begin
                    found = 1; n_grant = (m_grant + k) % N;
                end
            if (found) begin n_phase = 1; n_wait = 0; end
        end else if (m_phase == 1) begin
            if (src_has(m_grant)) begin
                n_data = fq[m_grant][0][7:0]; n_last = fq[m_grant][0][8];
                n_rd_en[m_grant] = 1'b1; n_valid = 1; n_wait = 0; n_phase = 2;
            end else begin
                n_wait = (m_wait + 1 > SM) ? SM : m_wait + 1;
                if (n_wait == SM) begin n_abort = 1; n_phase = 0; end
            end
        end else if (m_valid && tx_ready) begin
            n_valid = 0;
            n_phase = m_last ? 0 : 1;
        end
        pop = m_rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (pop[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        m_phase = n_phase; m_grant = n_grant; m_wait = n_wait; m_last = n_last;
        m_valid = n_valid; m_data = n_data; m_abort = n_abort; m_rd_en = n_rd_en;
        m_busy = (n_phase != 0);
        steps++;
        check("tx_valid", tx_valid, m_valid);
        if (m_valid) check("tx_data", tx_data, m_data);
        check("src_rd_en", src_rd_en, m_rd_en);
        check("grant", grant, m_grant);
        check("busy", busy, m_busy);
        check("stall_abort", stall_abort, m_abort);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            fq[i].delete(); hist[i].delete();
            sent_idx[i] = 0; rd_pulses[i] = 0; hold[i] = 0; hold_cnt[i] = 0;
        end
        txlog.delete();
        aborts = 0;
        drive_srcs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", grant, N - 1);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cap, t0, t1, len, s;
        steps = 0;

        // single source, three-byte packet
        do_reset();
        run(3);
        push(0, 8'hA1, 0); push(0, 8'hA2, 0); push(0, 8'hA3, 1);
        step(); check("t1_lat_cycle1", tx_valid, 0);
        step(); check("t1_lat_cycle2", tx_valid, 1);
        check("t1_first_byte", tx_data, 8'hA1);
        run(10);
        check("t1_count", txlog.size(), 3);
        check("t1_b0", logget(0), 8'hA1);
        check("t1_b1", logget(1), 8'hA2);
        check("t1_b2", logget(2), 8'hA3);
        check("t1_pops", rd_pulses[0], 3);
        check("t1_busy_end", busy, 0);

        // simultaneous requests; source 0 re-requests but source 1 goes next
        do_reset();
        push(0, 8'h10, 0); push(0, 8'h11, 1); push(0, 8'h12, 0); push(0, 8'h13, 1);
        push(1, 8'h20, 0); push(1, 8'h21, 1);
        run(30);
        check("t2_b0", logget(0), 8'h10);
        check("t2_b1", logget(1), 8'h11);
        check("t2_b2", logget(2), 8'h20);
        check("t2_b3", logget(3), 8'h21);
        check("t2_b4", logget(4), 8'h12);
        check("t2_b5", logget(5), 8'h13);

        // backpressure
        do_reset();
        tx_ready = 1'b0;
        push(0, 8'h77, 0); push(0, 8'h78, 1);
        run(2);
        repeat (50) begin
            step();
            check("t3_hold_valid", tx_valid, 1);
            check("t3_hold_data", tx_data, 8'h77);
        end
        check("t3_single_pop", rd_pulses[0], 1);
        check("t3_no_xfer", txlog.size(), 0);
        tx_ready = 1'b1;
        step();
        check("t3_xfer_now", logget(0), 8'h77);
        run(10);
        check("t3_second", logget(1), 8'h78);

        // mid-packet underflow keeps the grant
        do_reset();
        push(1, 8'h55, 0);
        step();
        push(0, 8'h01, 0); push(0, 8'h02, 1);
        run(22);
        push(1, 8'h56, 1);
        run(20);
        check("t4_b0", logget(0), 8'h55);
        check("t4_b1", logget(1), 8'h56);
        check("t4_b2", logget(2), 8'h01);
        check("t4_b3", logget(3), 8'h02);
        check("t4_no_abort", aborts, 0);

        // stall timeout
        do_reset();
        push(0, 8'h66, 0);
        step();
        push(1, 8'h88, 1);
        cap = 0;
        while (txlog.size() < 1 && cap < 20) begin step(); cap++; end
        check("t5_first_xfer", txlog.size(), 1);
        t0 = steps;
        cap = 0;
        while (!stall_abort && cap < 80) begin step(); cap++; end
        t1 = steps;
        check("t5_abort_delay", t1 - t0, SM);
        run(10);
        check("t5_abort_once", aborts, 1);
        check("t5_next_src", logget(1), 8'h88);

        // asynchronous reset mid-packet
        do_reset();
        tx_ready = 1'b0;
        push(0, 8'h99, 1);
        run(2);
        check("t6_in_send", tx_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_valid", tx_valid, 0);
        check("t6_rst_data", tx_data, 0);
        check("t6_rst_rd_en", src_rd_en, 0);
        check("t6_rst_grant", grant, N - 1);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_abort", stall_abort, 0);
        do_reset();
        push(1, 8'hB1, 1); push(0, 8'hC1, 1);
        run(12);
        check("t6_restart_b0", logget(0), 8'hC1);
        check("t6_restart_b1", logget(1), 8'hB1);

        // randomized traffic with gaps, backpressure and occasional timeouts
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                s = $urandom_range(0, N - 1);
                if (fq[s].size() < 12) begin
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++) push(s, 8'($urandom), j == len - 1);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (hold_cnt[i] > 0) hold_cnt[i]--;
                else if ($urandom_range(0, 59) == 0) hold_cnt[i] = $urandom_range(1, 45);
                hold[i] = (hold_cnt[i] > 0);
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        for (int i = 0; i < N; i++) begin hold[i] = 0; hold_cnt[i] = 0; end
        tx_ready = 1'b1;
        run(300);
        for (int i = 0; i < N; i++) check("rand_drained", sent_idx[i], hist[i].size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
